// File: rtl/ahfp_pkg.sv
// Shared float/fixed definitions for the ahfp float<->fixed conversion stages.
// Float field layout, fixed-point saturation limits and input classification.
package ahfp_pkg;

    localparam int FLOAT_W  = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int FIXED_W  = 32;

    localparam logic [FIXED_W-1:0] FIX_POS_MAX = 32'h7FFF_FFFF;
    localparam logic [FIXED_W-1:0] FIX_NEG_MAX = 32'h8000_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } float_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } float_cls_e;

    function automatic float_t unpack_float(input logic [FLOAT_W-1:0] bits);
        return float_t'(bits);
    endfunction

    // Denormals are grouped with zero: the converter flushes them.
    function automatic float_cls_e classify(input float_t f);
        if (f.exp == '1)
            return (f.man != '0) ? CLS_NAN : CLS_INF;
        else if (f.exp == '0)
            return CLS_ZERO;
        else
            return CLS_NORM;
    endfunction

endpackage

// File: rtl/ahfp_barrel_shift.sv
// Shifts the 24-bit significand by a signed amount into a 32-bit magnitude.
// Right shifts also report guard and sticky bits of the shifted-out field.
module ahfp_barrel_shift (
    input  logic [23:0]       man_in,
    input  logic signed [9:0] shift,
    output logic [31:0]       mag,
    output logic              guard,
    output logic              sticky
);

    logic [63:0] ext;
    logic [5:0]  rsh;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        ext    = '0;
        rsh    = '0;
        if (shift >= 10'sd0) begin
            // Amounts past 8 overflow and are saturated by the caller.
            if (shift > 10'sd8)
                mag = {man_in, 8'b0};
            else
                mag = {8'b0, man_in} << shift[3:0];
        end else begin
            // Beyond 33 places everything lands below the guard bit anyway.
            rsh    = (shift < -10'sd33) ? 6'd33 : 6'(-shift);
            ext    = {8'b0, man_in, 32'b0} >> rsh;
            mag    = ext[63:32];
            guard  = ext[31];
            sticky = |ext[30:0];
        end
    end

endmodule

// File: rtl/ahfp_float_2_fixed.sv
// IEEE-754 single to signed fixed-point (Q(31-FRAC_BITS).FRAC_BITS) converter, two-stage valid/ready pipeline.
// Define AHFP_F2X_ROUND_EN for round-to-nearest-even on right shifts; otherwise magnitudes truncate.
module ahfp_float_2_fixed
    import ahfp_pkg::*;
#(
    parameter int FRAC_BITS = 29
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOAT_W-1:0] in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [FIXED_W-1:0] out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sat,
    output logic               out_nan
);

    localparam int S_OFFSET = 150 - FRAC_BITS;

    float_t             f;
    float_cls_e         cls;
    logic signed [9:0]  shift_amt;
    logic [FIXED_W-1:0] sh_mag;
    logic               sh_guard;
    logic               sh_sticky;

    logic               ld1, ld2;
    logic               v1, v2;
    logic               sign1, sat1, nan1;
    logic [FIXED_W-1:0] mag1;

    logic               sat_c, nan_c;
    logic [FIXED_W-1:0] mag_c;
    logic [FIXED_W-1:0] out_c;

    assign ld2      = !v2 || out_ready;
    assign ld1      = !v1 || ld2;
    assign in_ready = !v1 || !v2 || out_ready;

    assign f         = unpack_float(in);
    assign cls       = classify(f);
    assign shift_amt = signed'({2'b00, f.exp}) - signed'(10'(S_OFFSET));

    ahfp_barrel_shift u_shift (
        .man_in (f.exp == '0 ? 24'd0 : {1'b1, f.man}),
        .shift  (shift_amt),
        .mag    (sh_mag),
        .guard  (sh_guard),
        .sticky (sh_sticky)
    );

`ifdef AHFP_F2X_ROUND_EN
    logic [FIXED_W:0] rnd_sum;
    assign rnd_sum = {1'b0, sh_mag} + {{FIXED_W{1'b0}}, sh_guard && (sh_sticky || sh_mag[0])};
`else
    logic unused_round;
    assign unused_round = sh_guard | sh_sticky;
`endif

    always_comb begin
        sat_c = 1'b0;
        nan_c = 1'b0;
        mag_c = '0;
        case (cls)
            CLS_NAN:  nan_c = 1'b1;
            CLS_INF:  sat_c = 1'b1;
            CLS_ZERO: mag_c = '0;
            default: begin
                if (shift_amt >= 10'sd8) begin
                    // Exactly -4.0 is the one overflow-range value that is representable.
                    if (f.sign && shift_amt == 10'sd8 && f.man == '0)
                        mag_c = FIX_NEG_MAX;
                    else
                        sat_c = 1'b1;
                end else if (shift_amt >= 10'sd0) begin
                    mag_c = sh_mag;
                end else begin
`ifdef AHFP_F2X_ROUND_EN
                    if (rnd_sum[FIXED_W] || rnd_sum[FIXED_W-1])
                        sat_c = 1'b1;
                    else
                        mag_c = rnd_sum[FIXED_W-1:0];
`else
                    mag_c = sh_mag;
`endif
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: pipeline data registers are few, so they are reset along with the valids for a clean reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            sign1 <= 1'b0;
            sat1  <= 1'b0;
            nan1  <= 1'b0;
            mag1  <= '0;
        end else if (ld1) begin
            v1 <= in_valid;
            if (in_valid) begin
                sign1 <= f.sign;
                sat1  <= sat_c;
                nan1  <= nan_c;
                mag1  <= mag_c;
            end
        end
    end

    always_comb begin
        out_c = mag1;
        if (sat1)
            out_c = sign1 ? FIX_NEG_MAX : FIX_POS_MAX;
        else if (sign1)
            out_c = -mag1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2      <= 1'b0;
            out     <= '0;
            out_sat <= 1'b0;
            out_nan <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                out     <= out_c;
                out_sat <= sat1;
                out_nan <= nan1;
            end
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_ahfp_float_2_fixed.sv
// Self-checking bench for ahfp_float_2_fixed: real-arithmetic reference model plus directed literal vectors.
// Honours AHFP_F2X_ROUND_EN to select the rounding variant of the expectations.
module tb_ahfp_float_2_fixed;

    localparam int FRAC = 29;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dout;
    logic        out_valid;
    logic        out_ready;
    logic        out_sat;
    logic        out_nan;

    int n_checks = 0;
    int n_fail   = 0;
    int out_count = 0;

    logic [31:0] q[$];
    logic        held = 1'b0;
    logic [33:0] prev_out = '0;

    ahfp_float_2_fixed #(.FRAC_BITS(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat),
        .out_nan   (out_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: value = 1.man * 2^(exp-127) scaled by 2^FRAC, then truncated or rounded half-even.
    function automatic void model(input logic [31:0] x, output logic [31:0] o,
                                  output logic s, output logic n);
        logic   sg;
        int     e, m;
        real    v, r, two31;
        longint li;
        sg = x[31];
        e = int'(x[30:23]);
        m = int'(x[22:0]);
        o = '0; s = 1'b0; n = 1'b0;
        two31 = 2147483648.0;
        if (e == 255) begin
            if (m != 0) n = 1'b1;
            else begin s = 1'b1; o = sg ? 32'h8000_0000 : 32'h7FFF_FFFF; end
            return;
        end
        if (e == 0) return;
        v = (1.0 + real'(m) / 8388608.0) * (2.0 ** real'(e - 127 + FRAC));
        r = $floor(v);
`ifdef AHFP_F2X_ROUND_EN
        if ((v - r) > 0.5 || ((v - r) == 0.5 && $floor(r / 2.0) * 2.0 != r))
            r = r + 1.0;
`endif
        if (r > two31 || (r == two31 && !(sg && v == two31))) begin
            s = 1'b1;
            o = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            li = longint'(r);
            o = sg ? 32'(-li) : 32'(li);
        end
    endfunction

    // Scoreboard/compare process: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        logic [31:0] e_o;
        logic        e_s, e_n, x;
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            check("in_ready", {33'b0, in_ready}, {33'b0, !(q.size() == 2 && !out_ready)});
            if (held)
                check("stall_hold", {dout, out_sat, out_nan}, prev_out);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", {33'b0, out_valid}, 34'd0);
                end else if (out_ready) begin
                    x = 1'b0;
                    model(q.pop_front(), e_o, e_s, e_n);
                    check("model_out", {2'b0, dout}, {2'b0, e_o});
                    check("model_flags", {32'b0, out_sat, out_nan}, {32'b0, e_s, e_n});
                    out_count++;
                end
            end
            held = out_valid && !out_ready;
            prev_out = {dout, out_sat, out_nan};
            if (in_valid && in_ready) q.push_back(din);
        end
    end

    task automatic send_one(input logic [31:0] x, input logic [31:0] e_out,
                            input logic e_sat, input logic e_nan, input string name);
        int lat;
        @(posedge clk); #1;
        din = x; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 34'(lat), 34'd2);
        check({name, "_out"}, {2'b0, dout}, {2'b0, e_out});
        check({name, "_flags"}, {32'b0, out_sat, out_nan}, {32'b0, e_sat, e_nan});
    endtask

`ifdef AHFP_F2X_ROUND_EN
    localparam logic [31:0] R15 = 32'd2, R25 = 32'd2, R35 = 32'd4;
`else
    localparam logic [31:0] R15 = 32'd1, R25 = 32'd2, R35 = 32'd3;
`endif

    initial begin
        logic [31:0] burst [8];
        int idx, cyc, start;
        logic fire;
        burst = '{32'h3F80_0000, 32'hBFC0_0000, 32'h4000_0000, 32'hC07F_FFFF,
                  32'h3E80_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000};
        rst = 1'b1; din = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {33'b0, out_valid}, 34'd0);
        check("rst_out", {2'b0, dout}, 34'd0);
        check("rst_flags", {32'b0, out_sat, out_nan}, 34'd0);
        check("rst_in_ready", {33'b0, in_ready}, 34'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        send_one(32'h3F80_0000, 32'h2000_0000, 1'b0, 1'b0, "one");
        send_one(32'hBFC0_0000, 32'hD000_0000, 1'b0, 1'b0, "neg_1p5");
        send_one(32'h40A0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, "five_sat");
        send_one(32'hC080_0000, 32'h8000_0000, 1'b0, 1'b0, "neg_four");
        send_one(32'h4080_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, "pos_four_sat");
        send_one(32'h407F_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, "max_below_four");
        send_one(32'hC07F_FFFF, 32'h8000_0080, 1'b0, 1'b0, "neg_below_four");
        send_one(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, "neg_inf");
        send_one(32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, "nan");
        send_one(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, "denormal");
        send_one(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, "neg_zero");
        send_one(32'h3080_0000, 32'h0000_0000, 1'b0, 1'b0, "tiny_trunc");
        send_one(32'h3140_0000, R15, 1'b0, 1'b0, "lsb_1p5");
        send_one(32'h31A0_0000, R25, 1'b0, 1'b0, "lsb_2p5");
        send_one(32'h31E0_0000, R35, 1'b0, 1'b0, "lsb_3p5");

        // Burst with random backpressure and a forced three-cycle stall mid-stream.
        @(posedge clk); #1;
        start = out_count; idx = 0; cyc = 0;
        din = burst[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (out_count - start < 8 && cyc < 200) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (fire) begin
                idx++;
                if (idx < 8) din = burst[idx];
                else in_valid = 1'b0;
            end
            out_ready = (cyc >= 4 && cyc < 7) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        check("burst_count", 34'(out_count - start), 34'd8);
        check("burst_drained", 34'(q.size()), 34'd0);

        // Reset with both stages occupied and stalled.
        out_ready = 1'b0;
        @(posedge clk); #1;
        din = 32'h3F80_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        din = 32'hBFC0_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_full", {32'b0, out_valid, in_ready}, 34'b10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("async_rst_out_valid", {33'b0, out_valid}, 34'd0);
        @(posedge clk); #1;
        check("rst_edge_out_valid", {33'b0, out_valid}, 34'd0);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle", {32'b0, out_valid, in_ready}, 34'b01);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
